// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL configuration sequencer: FSM states, ratio
// field selectors, the captured request and a beat-selection helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISABLE   = 3'd1,
    SETTLE    = 3'd2,
    WRITE     = 3'd3,
    WAIT_LOCK = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } state_t;

  localparam logic [1:0] RSEL_NONE  = 2'd0;
  localparam logic [1:0] RSEL_CORE  = 2'd1;
  localparam logic [1:0] RSEL_ZDIV0 = 2'd2;
  localparam logic [1:0] RSEL_ZDIV1 = 2'd3;

  typedef struct packed {
    logic [9:0] ratio;
    logic [9:0] zdiv0;
    logic [9:0] zdiv1;
    logic [1:0] vcodiv;
    logic [2:0] mask;
    logic       relock;
  } pll_req_t;

  // Selector of the next beat: lowest pending mask bit wins (core first).
  function automatic logic [1:0] first_sel(input logic [2:0] m);
    if (m[0])      return RSEL_CORE;
    else if (m[1]) return RSEL_ZDIV0;
    else if (m[2]) return RSEL_ZDIV1;
    else           return RSEL_NONE;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock, plus a registered
// falling-edge pulse of the synchronized level.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  output logic lock_s,
  output logic lock_fall
);

  logic meta;
  logic lock_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta      <= 1'b0;
      lock_s    <= 1'b0;
      lock_d    <= 1'b0;
      lock_fall <= 1'b0;
    end else begin
      meta      <= pll_lock;
      lock_s    <= meta;
      lock_d    <= lock_s;
      lock_fall <= lock_d & ~lock_s;
    end
  end

endmodule

// File: rtl/pll_cfg_sequencer.sv
// Frequency-change sequencer: optional relock, ratio write beats, lock wait.
// Optional lock-loss monitor enabled by defining PLL_CFG_SEQ_LOCK_MON_EN.
module pll_cfg_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int RELOCK_HOLD   = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TO_W          = $clog2(LOCK_TIMEOUT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_ratio,
  input  logic [9:0] req_zdiv0,
  input  logic [9:0] req_zdiv1,
  input  logic [1:0] req_vcodiv,
  input  logic [2:0] req_mask,
  input  logic       req_relock,
  input  logic       pll_lock,
  output logic       valid,
  output logic       pll_enable,
  output logic [1:0] pll_ratiosel,
  output logic [9:0] pll_ratio,
  output logic [1:0] pll_vcodiv_ratio,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       status_err,
  output logic [7:0] lock_loss_cnt,
  output state_t     dbg_state
);

  // Handshake: a request is taken on the edge where req_valid & req_ready
  // are both high; req_ready is high only in IDLE, so there is no queueing.
  localparam int PH_MAX = (RELOCK_HOLD > SETTLE_CYCLES) ? RELOCK_HOLD : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  state_t    state, state_nx;
  pll_req_t  req_q;
  logic [2:0] mask_left;
  logic [2:0] mask_after;
  logic [PH_W-1:0] ph_cnt;
  logic [TO_W-1:0] to_cnt;
  logic      lock_s;
  logic      lock_fall;
  logic      accept;
  logic      unused_relock;

  pll_lock_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .lock_s    (lock_s),
    .lock_fall (lock_fall)
  );

  assign accept           = (state == IDLE) && req_valid;
  assign req_ready        = (state == IDLE);
  assign busy             = (state != IDLE);
  assign pll_vcodiv_ratio = req_q.vcodiv;
  assign dbg_state        = state;
  assign mask_after       = mask_left & (mask_left - 3'd1);
  assign unused_relock    = req_q.relock;

  always_comb begin
    state_nx     = state;
    valid        = 1'b0;
    pll_enable   = 1'b1;
    pll_ratiosel = RSEL_NONE;
    pll_ratio    = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_relock)      state_nx = DISABLE;
          else if (|req_mask)  state_nx = WRITE;
          else                 state_nx = WAIT_LOCK;
        end
      end
      DISABLE: begin
        valid      = 1'b1;
        pll_enable = 1'b0;
        if (ph_cnt == PH_W'(RELOCK_HOLD - 1)) state_nx = SETTLE;
      end
      SETTLE: begin
        if (ph_cnt == PH_W'(SETTLE_CYCLES - 1))
          state_nx = (|req_q.mask) ? WRITE : WAIT_LOCK;
      end
      WRITE: begin
        valid        = 1'b1;
        pll_ratiosel = first_sel(mask_left);
        unique case (pll_ratiosel)
          RSEL_CORE:  pll_ratio = req_q.ratio;
          RSEL_ZDIV0: pll_ratio = req_q.zdiv0;
          RSEL_ZDIV1: pll_ratio = req_q.zdiv1;
          default:    pll_ratio = '0;
        endcase
        if (mask_after == 3'd0) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock wins over a timeout reached in the same cycle.
        if (lock_s)                                 state_nx = DONE;
        else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= '0;
      mask_left   <= '0;
      ph_cnt      <= '0;
      to_cnt      <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      status_err  <= 1'b0;
    end else begin
      state       <= state_nx;
      done        <= (state == DONE);
      err_timeout <= (state == ERR);
      ph_cnt      <= (state_nx == state && (state == DISABLE || state == SETTLE))
                     ? ph_cnt + 1'b1 : '0;
      to_cnt      <= (state_nx == state && state == WAIT_LOCK) ? to_cnt + 1'b1 : '0;
      if (state == ERR) status_err <= 1'b1;
      if (state == WRITE) mask_left <= mask_after;
      if (accept) begin
        req_q      <= '{ratio: req_ratio, zdiv0: req_zdiv0, zdiv1: req_zdiv1,
                        vcodiv: req_vcodiv, mask: req_mask, relock: req_relock};
        mask_left  <= req_mask;
        status_err <= 1'b0;
      end
    end
  end

`ifdef PLL_CFG_SEQ_LOCK_MON_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk) begin
    if (rst)
      loss_q <= '0;
    else if (accept)
      loss_q <= '0;
    else if (state == IDLE && lock_fall && loss_q != 8'hFF)
      loss_q <= loss_q + 8'd1;
  end

  assign lock_loss_cnt = loss_q;
`else
  logic unused_fall;
  assign unused_fall   = lock_fall;
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Bench for pll_cfg_sequencer: per-request expected output traces built from
// the sequencing rules, compared against the DUT every cycle.
module tb_pll_cfg_sequencer;
  import pll_seq_pkg::*;

  localparam int LT = 16;
  localparam int RH = 4;
  localparam int SC = 4;

  typedef struct packed {
    logic       valid;
    logic       en;
    logic [1:0] sel;
    logic [9:0] ratio;
    logic [1:0] vcodiv;
    logic       busy;
    logic       ready;
    logic       done;
    logic       err;
    logic       serr;
    logic [7:0] loss;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_ratio, req_zdiv0, req_zdiv1;
  logic [1:0] req_vcodiv;
  logic [2:0] req_mask;
  logic       req_relock;
  logic       pll_lock;
  logic       valid, pll_enable;
  logic [1:0] pll_ratiosel;
  logic [9:0] pll_ratio;
  logic [1:0] pll_vcodiv_ratio;
  logic       busy, done, err_timeout, status_err;
  logic [7:0] lock_loss_cnt;
  state_t     dbg_state;

  logic [OBS_W-1:0] exp_q[$];
  logic [OBS_W-1:0] tr[$];
  logic [1:0] m_vcodiv = '0;
  logic       m_serr   = 1'b0;
  logic       chk_en   = 1'b0;
  int         n_checks = 0;
  int         n_pass   = 0;

  pll_cfg_sequencer #(
    .LOCK_TIMEOUT  (LT),
    .RELOCK_HOLD   (RH),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_ratio        (req_ratio),
    .req_zdiv0        (req_zdiv0),
    .req_zdiv1        (req_zdiv1),
    .req_vcodiv       (req_vcodiv),
    .req_mask         (req_mask),
    .req_relock       (req_relock),
    .pll_lock         (pll_lock),
    .valid            (valid),
    .pll_enable       (pll_enable),
    .pll_ratiosel     (pll_ratiosel),
    .pll_ratio        (pll_ratio),
    .pll_vcodiv_ratio (pll_vcodiv_ratio),
    .busy             (busy),
    .done             (done),
    .err_timeout      (err_timeout),
    .status_err       (status_err),
    .lock_loss_cnt    (lock_loss_cnt),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic obs_t idle_obs();
    obs_t o;
    o        = '0;
    o.en     = 1'b1;
    o.ready  = 1'b1;
    o.vcodiv = m_vcodiv;
    o.serr   = m_serr;
    return o;
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s act=%0d exp=%0d", name, act, exp);
  endtask

  // Expected trace from the cycle after the accept edge: relock hold, settle,
  // one beat per set mask bit, lock wait, DONE/ERR, then the idle pulse cycle.
  // r is the cycle (same numbering) from which pll_lock is high; the
  // synchronizer makes that visible two cycles later.
  task automatic build_trace(input logic relock, input logic [2:0] mask,
                             input logic [9:0] ra, input logic [9:0] z0,
                             input logic [9:0] z1, input logic [1:0] vc,
                             input int r, output int len);
    obs_t base, o;
    int s, j;
    logic [9:0] vals [3];
    vals[0] = ra; vals[1] = z0; vals[2] = z1;
    tr.delete();
    base = '0; base.en = 1'b1; base.vcodiv = vc; base.busy = 1'b1;
    if (relock) begin
      for (int i = 0; i < RH; i++) begin
        o = base; o.valid = 1'b1; o.en = 1'b0; tr.push_back(o);
      end
      for (int i = 0; i < SC; i++) tr.push_back(base);
    end
    for (int b = 0; b < 3; b++) begin
      if (mask[b]) begin
        o = base; o.valid = 1'b1; o.sel = 2'(b + 1); o.ratio = vals[b];
        tr.push_back(o);
      end
    end
    s = tr.size();
    j = r + 2 - s;
    if (j < 0) j = 0;
    o = base; o.busy = 1'b0; o.ready = 1'b1;
    if (j <= LT - 1) begin
      for (int i = 0; i <= j; i++) tr.push_back(base);
      tr.push_back(base);
      o.done = 1'b1; m_serr = 1'b0;
    end else begin
      for (int i = 0; i < LT; i++) tr.push_back(base);
      tr.push_back(base);
      o.err = 1'b1; o.serr = 1'b1; m_serr = 1'b1;
    end
    tr.push_back(o);
    m_vcodiv = vc;
    len = tr.size();
  endtask

  // mode 0: lock high throughout; 1: lock rises at cycle r; 2: lock stays low.
  task automatic run_txn(input logic relock, input logic [2:0] mask,
                         input logic [9:0] ra, input logic [9:0] z0,
                         input logic [9:0] z1, input logic [1:0] vc,
                         input int mode, input int r, input int rst_at,
                         output int len);
    int g, r_eff;
    g = $urandom_range(3, 6);
    for (int i = 0; i < g; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      pll_lock  = (mode == 0);
    end
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_relock = relock; req_mask = mask; req_vcodiv = vc;
    req_ratio  = ra; req_zdiv0 = z0; req_zdiv1 = z1;
    pll_lock   = (mode == 0);
    r_eff = (mode == 0) ? -10 : (mode == 1) ? r : 1000000;
    @(posedge clk); #1;
    build_trace(relock, mask, ra, z0, z1, vc, r_eff, len);
    if (rst_at >= 0) begin
      while (tr.size() > rst_at + 1) void'(tr.pop_back());
      m_vcodiv = '0; m_serr = 1'b0;
      len = rst_at + 2;
    end
    foreach (tr[i]) exp_q.push_back(tr[i]);
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      pll_lock   = (mode == 0) ? 1'b1 : (mode == 1) ? (k >= r) : 1'b0;
      rst        = (k == rst_at);
      req_valid  = (k < len - 1 && (rst_at < 0 || k < rst_at)) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_relock = 1'($urandom_range(0, 1));
      req_mask   = 3'($urandom_range(0, 7));
      req_ratio  = 10'($urandom);
      req_zdiv0  = 10'($urandom);
      req_zdiv1  = 10'($urandom);
      req_vcodiv = 2'($urandom);
    end
  endtask

  // scoreboard: one comparison per cycle against the expected queue or idle
  always @(negedge clk) begin
    if (chk_en) begin
      obs_t e, a;
      if (exp_q.size() != 0) e = obs_t'(exp_q.pop_front());
      else e = idle_obs();
      a = {valid, pll_enable, pll_ratiosel, pll_ratio, pll_vcodiv_ratio,
           busy, req_ready, done, err_timeout, status_err, lock_loss_cnt};
`ifdef PLL_CFG_SEQ_LOCK_MON_EN
      a.loss = '0;
      e.loss = '0;
`endif
      n_checks++;
      if (a == e) n_pass++;
      else $display("FAIL cycle_cmp t=%0t state=%0d act v/en/sel/ratio/vc/busy/rdy/done/err/serr=%0b/%0b/%0d/%h/%0d/%0b/%0b/%0b/%0b/%0b exp=%0b/%0b/%0d/%h/%0d/%0b/%0b/%0b/%0b/%0b",
                    $time, dbg_state, a.valid, a.en, a.sel, a.ratio, a.vcodiv, a.busy, a.ready,
                    a.done, a.err, a.serr, e.valid, e.en, e.sel, e.ratio, e.vcodiv, e.busy,
                    e.ready, e.done, e.err, e.serr);
    end
  end

  initial begin
    int len;
    obs_t t;
    logic [2:0] m;
    logic rl;
    int mode, s_est;

    rst = 1'b1; req_valid = 1'b0; req_relock = 1'b0; req_mask = '0;
    req_ratio = '0; req_zdiv0 = '0; req_zdiv1 = '0; req_vcodiv = '0; pll_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_valid", int'(valid), 0);
    check_val("rst_enable", int'(pll_enable), 1);
    check_val("rst_ready", int'(req_ready), 1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ratio", int'(pll_ratio), 0);
    check_val("rst_status_err", int'(status_err), 0);
    check_val("rst_loss", int'(lock_loss_cnt), 0);

    // three beats, lock already high
    run_txn(1'b0, 3'b111, 10'h0BC, 10'h0C7, 10'h019, 2'd2, 0, 0, -1, len);
    check_val("pin_w7_len", len, 6);
    t = obs_t'(tr[0]); check_val("pin_w7_beat1_ratio", int'(t.ratio), 'h0BC);
    t = obs_t'(tr[2]); check_val("pin_w7_beat3_sel", int'(t.sel), 3);
    t = obs_t'(tr[5]); check_val("pin_w7_done", int'(t.done), 1);

    // relock then a single zdiv0 beat
    run_txn(1'b1, 3'b010, 10'h011, 10'h155, 10'h022, 2'd1, 0, 0, -1, len);
    check_val("pin_relock_len", len, 12);
    t = obs_t'(tr[3]); check_val("pin_relock_en", int'(t.en), 0);
    t = obs_t'(tr[8]); check_val("pin_relock_sel", int'(t.sel), 2);

    // timeout, then the next accept clears status_err
    run_txn(1'b0, 3'b000, 10'h001, 10'h002, 10'h003, 2'd3, 2, 0, -1, len);
    check_val("pin_to_len", len, 18);
    t = obs_t'(tr[17]); check_val("pin_to_err", int'(t.err & t.serr), 1);
    run_txn(1'b0, 3'b001, 10'h3FF, 10'h000, 10'h000, 2'd0, 0, 0, -1, len);
    t = obs_t'(tr[0]); check_val("pin_clear_serr", int'(t.serr), 0);

    // lock seen on the last counter value, then one cycle too late
    run_txn(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd1, 1, 13, -1, len);
    t = obs_t'(tr[len-1]); check_val("pin_edge_done", int'(t.done), 1);
    run_txn(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd2, 1, 14, -1, len);
    t = obs_t'(tr[len-1]); check_val("pin_edge_err", int'(t.err), 1);

    // reset during the second write beat
    run_txn(1'b0, 3'b111, 10'h0AA, 10'h0BB, 10'h0CC, 2'd3, 0, 0, 1, len);
    @(negedge clk);
    check_val("rst_mid_valid", int'(valid), 0);
    check_val("rst_mid_busy", int'(busy), 0);

    for (int n = 0; n < 40; n++) begin
      rl    = 1'($urandom_range(0, 3) == 0);
      m     = 3'($urandom_range(0, 7));
      mode  = $urandom_range(0, 2);
      s_est = (rl ? RH + SC : 0) + $countones(m);
      run_txn(rl, m, 10'($urandom), 10'($urandom), 10'($urandom), 2'($urandom),
              mode, $urandom_range(0, s_est + LT), -1, len);
    end

`ifdef PLL_CFG_SEQ_LOCK_MON_EN
    run_txn(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd0, 0, 0, -1, len);
    for (int i = 0; i < 300; i++) begin
      repeat (4) begin @(posedge clk); #1; pll_lock = 1'b0; end
      repeat (4) begin @(posedge clk); #1; pll_lock = 1'b1; end
      if (i == 2) begin
        @(negedge clk);
        check_val("mon_three_drops", int'(lock_loss_cnt), 3);
      end
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("mon_saturate", int'(lock_loss_cnt), 255);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("exp_q_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
